ahb_slave_mem: RTL and testbench
================================

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 Parameter DATA_W, default 32, data bus width (fixed at 32).
REQ-002 Parameter ADDR_W, default 32, address bus width.
REQ-003 Parameter MEM_DEPTH, default 256, number of 32-bit words (power of two).
REQ-004 Parameter WAIT_CYCLES, default 2, wait states per transfer when wait insertion is compiled in.
REQ-005 Port hclk, input, 1 bit, sole clock; all logic on its rising edge.
REQ-006 Port hreset, input, 1 bit, asynchronous active-low reset.
REQ-007 Port s_hsel, input, 1 bit, slave select from the decoder.
REQ-008 Port s_haddr, input, ADDR_W bits, address-phase address.
REQ-009 Port s_htrans, input, 2 bits, transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-010 Port s_hwrite, input, 1 bit, 1 = write.
REQ-011 Port s_hsize, input, 3 bits, transfer size: 0 = byte, 1 = half, 2 = word.
REQ-012 Port s_hburst, input, 3 bits, burst type; accepted and ignored.
REQ-013 Port s_hwdata, input, DATA_W bits, data-phase write data.
REQ-014 Port s_hready, input, 1 bit, bus-level HREADY (previous transfer complete).
REQ-015 Port s_hreadyout, output, 1 bit, slave ready for the current data phase.
REQ-016 Port s_hresp, output, 2 bits, response: OKAY=0, ERROR=1; RETRY and SPLIT are never driven.
REQ-017 Port s_hrdata, output, DATA_W bits, data-phase read data.

Function
REQ-018 An address phase is accepted only in a cycle where s_hsel=1, s_hready=1 and s_htrans is NONSEQ or SEQ; the block latches haddr, hwrite and hsize in that cycle.
REQ-019 IDLE or BUSY transfers, or s_hsel=0, produce an OKAY zero-wait data phase with no memory access.
REQ-020 State machine: IDLE, ACCESS, WAIT, ERR1, ERR2.
- IDLE --accepted valid--> ACCESS (or WAIT when wait states are enabled).
- Accepted invalid --> ERR1.
REQ-021 A transfer is invalid if any of: word index (haddr[log2(MEM_DEPTH)+1:2]) is at or above MEM_DEPTH (upper address bits nonzero), s_hsize > 2, or the address is misaligned (half with haddr[0]=1; word with haddr[1:0] != 0).
REQ-022 Invalid transfer response: ERR1 drives hresp=ERROR, hreadyout=0; next cycle ERR2 drives hresp=ERROR, hreadyout=1. Memory is not modified.
REQ-023 Write: the write completes in the data-phase cycle with hreadyout=1; only byte lanes selected by hsize and haddr[1:0] are updated (little-endian).
REQ-024 Read: s_hrdata holds the full addressed word during the completing data-phase cycle; otherwise s_hrdata=0.
REQ-025 Back-to-back pipelining: a new address phase accepted in the completing cycle of the previous transfer starts with no bubble.
REQ-026 A read immediately following a write to the same word returns the newly written data.
REQ-027 s_hreadyout=1 and s_hresp=OKAY whenever no data phase is pending.

Reset
REQ-028 While hreset=0: state=IDLE, s_hreadyout=1, s_hresp=OKAY, s_hrdata=0, latched address-phase registers cleared.
REQ-029 Memory contents are undefined after reset and need not be cleared.
REQ-030 Reset asserted mid-transfer aborts the transfer immediately and suppresses any pending write.

Configuration
REQ-031 With macro AHB_SLV_WAIT_EN defined:
- Each valid transfer holds hreadyout=0 for exactly WAIT_CYCLES cycles in state WAIT, then completes in ACCESS.
- WAIT_CYCLES=0 behaves as zero-wait.
REQ-032 Without AHB_SLV_WAIT_EN: the WAIT state and its counter are absent, and every valid transfer completes in its first data-phase cycle.
REQ-033 Error responses are always two cycles, with or without the macro.

Verification
REQ-034 Word write of 0xDEADBEEF to 0x10, then read of 0x10 -> hrdata=0xDEADBEEF, hresp=OKAY, no wait (macro off).
REQ-035 Byte write of 0xAA to 0x13 over word 0x11223344 -> subsequent read returns 0xAA223344.
REQ-036 Read of 0x400 with MEM_DEPTH=256 -> ERROR with hreadyout=0, then ERROR with hreadyout=1; the next transfer is OKAY.
REQ-037 With AHB_SLV_WAIT_EN and WAIT_CYCLES=2, a word read -> hreadyout low for 2 cycles, and data is valid on the third cycle.
REQ-038 NONSEQ write at 0x0 followed directly by SEQ read at 0x0 -> the read returns the written value with no bubble.
REQ-039 hreset pulled low during the data phase of a write to 0x8 -> outputs return to reset values, and a read of 0x8 after reset does not show the aborted data.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem -- AHB-Lite slave backed by a MEM_DEPTH x 32-bit memory.
//
// Accepts an address phase when s_hsel & s_hready & (NONSEQ|SEQ). Valid
// transfers complete with OKAY. A write updates only the byte lanes picked by
// hsize/haddr[1:0]. A read returns the whole addressed word on s_hrdata during
// the completing cycle. Out-of-range, oversize or misaligned transfers get a
// two-cycle ERROR response and leave memory untouched.
//
// Build option: define AHB_SLV_WAIT_EN to add WAIT_CYCLES wait states ahead of
// every valid data phase. Without it, valid transfers complete with no wait.
//
// Ports:
//   hclk, hreset          clock, async active-low reset
//   s_hsel .. s_hready    AHB address/control/write-data inputs (hburst ignored)
//   s_hreadyout, s_hresp  data-phase handshake/response (OKAY=0, ERROR=1)
//   s_hrdata              read data, zero outside a completing read
module ahb_slave_mem #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              s_hsel,
    input  logic [ADDR_W-1:0] s_haddr,
    input  logic [1:0]        s_htrans,
    input  logic              s_hwrite,
    input  logic [2:0]        s_hsize,
    input  logic [2:0]        s_hburst,
    input  logic [DATA_W-1:0] s_hwdata,
    input  logic              s_hready,
    output logic              s_hreadyout,
    output logic [1:0]        s_hresp,
    output logic [DATA_W-1:0] s_hrdata
);

    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam int NUM_LANES = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
`ifdef AHB_SLV_WAIT_EN
        S_WAIT   = 3'd2,
`endif
        S_ERR1   = 3'd3,
        S_ERR2   = 3'd4
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       lo;
        logic [2:0]       size;
        logic             wr;
    } req_t;

    state_t state, nxt, go;
    req_t   req;
    logic   acc, bad, upper_nz, misal, rd_en;
    logic [NUM_LANES-1:0]      be;
    logic [NUM_LANES-1:0][7:0] mem [MEM_DEPTH];

    logic unused_ok;
    assign unused_ok = ^{s_hburst, s_htrans[0], (WAIT_CYCLES != 0)};

    // Address-phase decode. htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
    assign acc      = s_hsel & s_hready & s_htrans[1];
    assign upper_nz = |(s_haddr >> (IDX_W + 2));
    assign misal    = ((s_hsize == 3'd1) & s_haddr[0]) |
                      ((s_hsize == 3'd2) & (|s_haddr[1:0]));
    assign bad      = upper_nz | (s_hsize > 3'd2) | misal;

    always_ff @(posedge hclk or negedge hreset) begin
        if (!hreset)  req <= '0;
        else if (acc) req <= '{idx: s_haddr[IDX_W+1:2], lo: s_haddr[1:0],
                               size: s_hsize, wr: s_hwrite};
    end

`ifdef AHB_SLV_WAIT_EN
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CW-1:0] wcnt;

    // Preloaded outside WAIT so the count is ready on entry; WAIT exits at 0.
    always_ff @(posedge hclk or negedge hreset) begin
        if (!hreset)              wcnt <= '0;
        else if (state != S_WAIT) wcnt <= CW'(WAIT_CYCLES - 1);
        else                      wcnt <= wcnt - 1'b1;
    end
`endif

    // Where a newly accepted address phase sends the data phase.
    always_comb begin
        go = S_IDLE;
        if (acc) begin
            if (bad)                  go = S_ERR1;
`ifdef AHB_SLV_WAIT_EN
            else if (WAIT_CYCLES > 0) go = S_WAIT;
`endif
            else                      go = S_ACCESS;
        end
    end

    always_ff @(posedge hclk or negedge hreset) begin
        if (!hreset) state <= S_IDLE;
        else         state <= nxt;
    end

    always_comb begin
        nxt         = state;
        s_hreadyout = 1'b1;
        s_hresp     = 2'd0;
        rd_en       = 1'b0;
        case (state)
            S_IDLE:   nxt = go;
            S_ACCESS: begin
                rd_en = ~req.wr;
                nxt   = go;
            end
`ifdef AHB_SLV_WAIT_EN
            S_WAIT: begin
                s_hreadyout = 1'b0;
                if (wcnt == '0) nxt = S_ACCESS;
            end
`endif
            S_ERR1: begin
                s_hreadyout = 1'b0;
                s_hresp     = 2'd1;
                nxt         = S_ERR2;
            end
            S_ERR2: begin
                s_hresp = 2'd1;
                nxt     = go;
            end
            default:  nxt = S_IDLE;
        endcase
    end

    // Little-endian byte lanes: half selects by lo[1], byte by lo[1:0].
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        localparam logic [1:0] LN = 2'(l);
        assign be[l] = (req.size == 3'd2) |
                       ((req.size == 3'd1) & (req.lo[1] == LN[1])) |
                       ((req.size == 3'd0) & (req.lo == LN));
    end

    // No reset on the array. An async reset forces state to IDLE, so an
    // in-flight write never reaches the edge.
    always_ff @(posedge hclk) begin
        if (state == S_ACCESS && req.wr) begin
            for (int l = 0; l < NUM_LANES; l++)
                if (be[l]) mem[req.idx][l] <= s_hwdata[8*l +: 8];
        end
    end

    // Combinational read sees the previous cycle's write, so read-after-write
    // to the same word needs no forwarding.
    assign s_hrdata = rd_en ? mem[req.idx] : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
module tb_ahb_slave_mem;
    localparam int MEM_DEPTH   = 256;
    localparam int WAIT_CYCLES = 2;
`ifdef AHB_SLV_WAIT_EN
    localparam int WAITS = WAIT_CYCLES;
`else
    localparam int WAITS = 0;
`endif

    logic        hclk = 1'b0;
    logic        hreset = 1'b0;
    logic        s_hsel, s_hwrite, s_hready, s_hreadyout;
    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic [1:0]  s_htrans, s_hresp;
    logic [2:0]  s_hsize, s_hburst;

    always #5 hclk = ~hclk;
    assign s_hready = s_hreadyout;   // single slave on the bus

    ahb_slave_mem #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(MEM_DEPTH),
                    .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .hclk(hclk), .hreset(hreset), .s_hsel(s_hsel), .s_haddr(s_haddr),
        .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hwdata(s_hwdata), .s_hready(s_hready),
        .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata));

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          has_exp;
        logic [31:0] exp;
    } xfer_t;

    xfer_t      q[$];
    logic [7:0] mb [MEM_DEPTH*4];   // reference memory, byte addressed
    int         checks = 0;
    int         failures = 0;

    // ---------------- reference model ----------------
    function automatic bit is_bad(xfer_t x);
        if (x.addr >= 32'(MEM_DEPTH*4)) return 1'b1;
        if (x.size > 3'd2) return 1'b1;
        return (x.addr % (32'd1 << x.size)) != 0;
    endfunction

    function automatic logic [31:0] model_word(logic [31:0] a);
        int base;
        base = int'(a) & ~3;
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    function automatic void model_write(xfer_t x);
        int ba;
        for (int b = 0; b < (1 << x.size); b++) begin
            ba = int'(x.addr) + b;
            mb[ba] = x.wdata[8*(ba%4) +: 8];
        end
    endfunction

    function automatic void push(logic wr, logic [2:0] size, logic [31:0] addr,
                                 logic [31:0] wdata, bit has_exp,
                                 logic [31:0] exp, logic [1:0] trans = 2'd2);
        xfer_t x;
        x.sel = 1'b1; x.trans = trans; x.wr = wr; x.size = size;
        x.addr = addr; x.wdata = wdata; x.has_exp = has_exp; x.exp = exp;
        q.push_back(x);
    endfunction

    task automatic drive_idle();
        s_hsel = 1'b0; s_htrans = 2'd0; s_hwrite = 1'b0; s_hsize = 3'd0;
        s_haddr = '0; s_hburst = 3'd0; s_hwdata = $urandom;
    endtask

    // Pipelined master: drives the queue head as the address phase while the
    // previous transfer occupies the data phase; checks every data-phase cycle.
    task automatic run_q(input string tag, output int cycles);
        xfer_t       dp, x;
        bit          dp_v, dp_bad, acc;
        int          wc, exp_w;
        logic [31:0] exp_rd;
        dp_v = 0; dp_bad = 0; wc = 0; exp_w = 0; cycles = 0;
        while ((q.size() > 0 || dp_v) && cycles < 4000) begin
            cycles++;
            if (q.size() > 0) begin
                s_hsel = q[0].sel; s_htrans = q[0].trans; s_hwrite = q[0].wr;
                s_hsize = q[0].size; s_haddr = q[0].addr;
                s_hburst = 3'($urandom_range(0, 7));
            end else begin
                s_hsel = 1'b0; s_htrans = 2'd0;
            end
            s_hwdata = dp_v ? dp.wdata : $urandom;
            @(negedge hclk);
            if (dp_v) begin
                if (s_hreadyout !== 1'b1) begin
                    wc++;
                    checks++;
                    if (s_hresp !== {1'b0, dp_bad} || wc > exp_w) begin
                        failures++;
                        $display("FAIL %s wait_cycle addr=%h got resp=%0d waits=%0d, want resp=%0d waits<=%0d",
                                 tag, dp.addr, s_hresp, wc, dp_bad, exp_w);
                    end
                end else begin
                    checks++;
                    if (wc != exp_w) begin
                        failures++;
                        $display("FAIL %s wait_count addr=%h got=%0d want=%0d", tag, dp.addr, wc, exp_w);
                    end
                    checks++;
                    if (s_hresp !== {1'b0, dp_bad}) begin
                        failures++;
                        $display("FAIL %s resp addr=%h got=%0d want=%0d", tag, dp.addr, s_hresp, dp_bad);
                    end
                    exp_rd = (!dp_bad && !dp.wr) ? model_word(dp.addr) : 32'h0;
                    checks++;
                    if (s_hrdata !== exp_rd) begin
                        failures++;
                        $display("FAIL %s rdata addr=%h wr=%0d got=%h want=%h", tag, dp.addr, dp.wr, s_hrdata, exp_rd);
                    end
                    if (dp.has_exp) begin
                        checks++;
                        if (s_hrdata !== dp.exp) begin
                            failures++;
                            $display("FAIL %s directed_rdata addr=%h got=%h want=%h", tag, dp.addr, s_hrdata, dp.exp);
                        end
                    end
                    if (!dp_bad && dp.wr) model_write(dp);
                    dp_v = 0;
                end
            end else begin
                checks++;
                if (s_hreadyout !== 1'b1 || s_hresp !== 2'd0 || s_hrdata !== 32'h0) begin
                    failures++;
                    $display("FAIL %s no_data_phase got ready=%b resp=%0d rdata=%h want 1/0/0",
                             tag, s_hreadyout, s_hresp, s_hrdata);
                end
            end
            acc = (s_hreadyout === 1'b1) && (q.size() > 0);
            @(posedge hclk); #1;
            if (acc) begin
                x = q.pop_front();
                if (x.sel && x.trans[1]) begin
                    dp = x; dp_v = 1; wc = 0;
                    dp_bad = is_bad(x);
                    exp_w  = dp_bad ? 1 : WAITS;
                end
            end
        end
        if (q.size() > 0 || dp_v) begin
            checks++; failures++;
            $display("FAIL %s timeout got pending=%0d want 0", tag, q.size());
            q.delete();
        end
        drive_idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        hreset = 1'b0;
        repeat (3) begin
            @(negedge hclk);
            checks++;
            if (s_hreadyout !== 1'b1 || s_hresp !== 2'd0 || s_hrdata !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs got ready=%b resp=%0d rdata=%h want 1/0/0",
                         s_hreadyout, s_hresp, s_hrdata);
            end
        end
        @(posedge hclk); #1;
        hreset = 1'b1;
    endtask

    task automatic test_fill();
        int cyc;
        for (int i = 0; i < MEM_DEPTH; i++)
            push(1'b1, 3'd2, 32'(i*4), $urandom, 1'b0, 32'h0);
        run_q("fill", cyc);
    endtask

    task automatic test_word_rw();
        int cyc;
        push(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        push(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        run_q("word_rw", cyc);
    endtask

    task automatic test_byte_merge();
        int cyc;
        push(1'b1, 3'd2, 32'h10, 32'h11223344, 1'b0, 32'h0);
        push(1'b1, 3'd0, 32'h13, 32'hAA000000, 1'b0, 32'h0);
        push(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hAA223344);
        push(1'b1, 3'd1, 32'h22, 32'h5A5A0000, 1'b0, 32'h0);
        push(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h0);
        run_q("byte_merge", cyc);
    endtask

    task automatic test_error();
        int cyc;
        push(1'b0, 3'd2, 32'h400, 32'h0, 1'b1, 32'h0);
        push(1'b1, 3'd2, 32'h12, 32'hFFFFFFFF, 1'b0, 32'h0);      // misaligned word
        push(1'b1, 3'd1, 32'h11, 32'hFFFFFFFF, 1'b0, 32'h0);      // misaligned half
        push(1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, 1'b0, 32'h0);      // oversize
        push(1'b1, 3'd2, 32'h80000010, 32'hFFFFFFFF, 1'b0, 32'h0); // upper bits
        push(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hAA223344);
        run_q("error", cyc);
    endtask

    task automatic test_back_to_back();
        int cyc, n;
        logic [31:0] v;
        v = $urandom;
        push(1'b1, 3'd2, 32'h0, v, 1'b0, 32'h0, 2'd2);
        push(1'b0, 3'd2, 32'h0, 32'h0, 1'b1, v, 2'd3);
        n = 2;
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 3'd2, 32'(i*4 + 64), $urandom, 1'b0, 32'h0, 2'd3);
            push(1'b0, 3'd2, 32'(i*4 + 64), 32'h0, 1'b0, 32'h0, 2'd3);
            n += 2;
        end
        run_q("back_to_back", cyc);
        checks++;
        if (cyc != 1 + n*(WAITS+1)) begin
            failures++;
            $display("FAIL back_to_back cycles got=%0d want=%0d", cyc, 1 + n*(WAITS+1));
        end
        push(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 32'h0);
        run_q("single_read", cyc);
        checks++;
        if (cyc != 2 + WAITS) begin
            failures++;
            $display("FAIL single_read cycles got=%0d want=%0d", cyc, 2 + WAITS);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        logic [31:0] old;
        old = model_word(32'h8);
        s_hsel = 1'b1; s_htrans = 2'd2; s_hwrite = 1'b1; s_hsize = 3'd2;
        s_haddr = 32'h8; s_hwdata = $urandom;
        @(posedge hclk); #1;
        s_hsel = 1'b0; s_htrans = 2'd0; s_hwdata = ~old;
        @(negedge hclk);
        hreset = 1'b0;
        #1;
        checks++;
        if (s_hreadyout !== 1'b1 || s_hresp !== 2'd0 || s_hrdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_abort_outputs got ready=%b resp=%0d rdata=%h want 1/0/0",
                     s_hreadyout, s_hresp, s_hrdata);
        end
        @(posedge hclk); #1;
        hreset = 1'b1;
        drive_idle();
        push(1'b0, 3'd2, 32'h8, 32'h0, 1'b1, old);
        run_q("reset_abort", cyc);
    endtask

    task automatic test_random();
        int cyc;
        for (int i = 0; i < 300; i++) begin
            xfer_t x;
            x.sel   = ($urandom_range(0, 9) != 0);
            x.trans = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            x.wr    = 1'($urandom_range(0, 1));
            x.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            x.addr  = ($urandom_range(0, 19) == 0) ? 32'(MEM_DEPTH*4 + $urandom_range(0, 255))
                                                   : 32'($urandom_range(0, MEM_DEPTH*4 - 1));
            if (x.size <= 3'd2 && $urandom_range(0, 3) != 0)
                x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
            x.wdata = $urandom; x.has_exp = 1'b0; x.exp = 32'h0;
            q.push_back(x);
        end
        run_q("random", cyc);
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_fill();
        test_word_rw();
        test_byte_merge();
        test_error();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
